// File: rtl/reg_bank_if.sv
// Operand-read, write-back and claim signals between the issue stage and reg_bank.
interface reg_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] op1_addr;
  logic [ADDR_W-1:0] op2_addr;
  logic              rd_stall;
  logic              rd_valid;
  logic [DATA_W-1:0] op1_data;
  logic [DATA_W-1:0] op2_data;
  logic [ADDR_W-1:0] op1_addr_q;
  logic [ADDR_W-1:0] op2_addr_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic [DATA_W-1:0] acc_out;

  modport master (
    output rd_req, op1_addr, op2_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_stall, rd_valid, op1_data, op2_data, op1_addr_q, op2_addr_q, acc_out
  );

  modport slave (
    input  rd_req, op1_addr, op2_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_stall, rd_valid, op1_data, op2_data, op1_addr_q, op2_addr_q, acc_out
  );
endinterface

// File: rtl/reg_bank.sv
// 16x16 register bank with pending-write scoreboard and registered operand reads.
// Define REG_BANK_BYPASS_EN to forward a same-cycle write-back into operand reads.
module reg_bank #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input logic        clk,
  input logic        rst_n,
  reg_bank_if.slave  bus
);

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   op1_data_q, op1_data_d;
  logic [DATA_W-1:0]   op2_data_q, op2_data_d;
  logic [ADDR_W-1:0]   op1_addr_q, op1_addr_d;
  logic [ADDR_W-1:0]   op2_addr_q, op2_addr_d;

  logic fwd1, fwd2, busy1, busy2, stall, accept;

  always_comb begin
    fwd1   = BYPASS && bus.wr_en && (bus.wr_addr == bus.op1_addr);
    fwd2   = BYPASS && bus.wr_en && (bus.wr_addr == bus.op2_addr);
    busy1  = pend_q[bus.op1_addr] && !fwd1;
    busy2  = pend_q[bus.op2_addr] && !fwd2;
    stall  = bus.rd_req && (busy1 || busy2);
    accept = bus.rd_req && !stall;

    regs_d = regs_q;
    pend_d = pend_q;
    if (bus.wr_en) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      pend_d[bus.wr_addr] = 1'b0;
    end
    // Claim is applied after the write so a same-address claim keeps the bit set.
    if (bus.claim_en) pend_d[bus.claim_addr] = 1'b1;

    rd_valid_d = accept;
    op1_data_d = op1_data_q;
    op2_data_d = op2_data_q;
    op1_addr_d = op1_addr_q;
    op2_addr_d = op2_addr_q;
    if (accept) begin
      op1_data_d = fwd1 ? bus.wr_data : regs_q[bus.op1_addr];
      op2_data_d = fwd2 ? bus.wr_data : regs_q[bus.op2_addr];
      op1_addr_d = bus.op1_addr;
      op2_addr_d = bus.op2_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      pend_q     <= '0;
      rd_valid_q <= 1'b0;
      op1_data_q <= '0;
      op2_data_q <= '0;
      op1_addr_q <= '0;
      op2_addr_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      op1_data_q <= op1_data_d;
      op2_data_q <= op2_data_d;
      op1_addr_q <= op1_addr_d;
      op2_addr_q <= op2_addr_d;
    end
  end

  assign bus.rd_stall   = stall;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.op1_data   = op1_data_q;
  assign bus.op2_data   = op2_data_q;
  assign bus.op1_addr_q = op1_addr_q;
  assign bus.op2_addr_q = op2_addr_q;
  assign bus.acc_out    = regs_q[0];

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios plus random traffic against an array-based model.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  reg_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_regs [16];
  bit          m_pend [16];
  bit          e_valid;
  logic [15:0] e_op1, e_op2;
  logic [3:0]  e_a1, e_a2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_pend[i] = 1'b0;
    end
    e_valid = 1'b0;
    e_op1 = 16'h0; e_op2 = 16'h0;
    e_a1 = 4'h0;   e_a2 = 4'h0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {31'b0, bus.rd_valid}, {31'b0, e_valid});
    chk({tag, ".op1"}, {16'b0, bus.op1_data}, {16'b0, e_op1});
    chk({tag, ".op2"}, {16'b0, bus.op2_data}, {16'b0, e_op2});
    chk({tag, ".a1q"}, {28'b0, bus.op1_addr_q}, {28'b0, e_a1});
    chk({tag, ".a2q"}, {28'b0, bus.op2_addr_q}, {28'b0, e_a2});
    chk({tag, ".acc"}, {16'b0, bus.acc_out}, {16'b0, m_regs[0]});
  endtask

  // One clock cycle: drive, check the combinational stall, clock, check registered outputs.
  task automatic cyc(input string tag, input bit req, input logic [3:0] a1, input logic [3:0] a2,
                     input bit we, input logic [3:0] wa, input logic [15:0] wd,
                     input bit ce, input logic [3:0] ca);
    bit hit1, hit2, exp_stall, acc;
    bus.rd_req = req; bus.op1_addr = a1; bus.op2_addr = a2;
    bus.wr_en = we;   bus.wr_addr = wa;  bus.wr_data = wd;
    bus.claim_en = ce; bus.claim_addr = ca;
    #1;
    hit1 = BYP && we && (wa == a1);
    hit2 = BYP && we && (wa == a2);
    exp_stall = req && ((m_pend[a1] && !hit1) || (m_pend[a2] && !hit2));
    chk({tag, ".stall"}, {31'b0, bus.rd_stall}, {31'b0, exp_stall});
    acc = req && !exp_stall;
    e_valid = acc;
    if (acc) begin
      e_op1 = hit1 ? wd : m_regs[a1];
      e_op2 = hit2 ? wd : m_regs[a2];
      e_a1 = a1; e_a2 = a2;
    end
    if (we) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (ce) m_pend[ca] = 1'b1;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    bus.rd_req = 0; bus.op1_addr = 0; bus.op2_addr = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.claim_en = 0; bus.claim_addr = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    cyc("rd35_zero", 1, 4'd3, 4'd5, 0, 0, 0, 0, 0);
    cyc("wr_r3", 0, 0, 0, 1, 4'd3, 16'h1234, 0, 0);
    cyc("wr_r5", 0, 0, 0, 1, 4'd5, 16'hBEEF, 0, 0);
    cyc("rd35", 1, 4'd3, 4'd5, 0, 0, 0, 0, 0);
    idle("idle0");

    cyc("claim7", 0, 0, 0, 0, 0, 0, 1, 4'd7);
    for (int i = 0; i < 3; i++) cyc("stall7", 1, 4'd7, 4'd1, 0, 0, 0, 0, 0);
    cyc("wr7_rd", 1, 4'd7, 4'd1, 1, 4'd7, 16'h00AA, 0, 0);
    cyc("rd7_after", 1, 4'd7, 4'd1, 0, 0, 0, 0, 0);
    chk("r7_value", {16'b0, bus.op1_data}, 32'h00AA);

    cyc("claimwr2", 0, 0, 0, 1, 4'd2, 16'h5555, 1, 4'd2);
    cyc("rd2_stall", 1, 4'd2, 4'd2, 0, 0, 0, 0, 0);
    cyc("rd2_stall2", 1, 4'd2, 4'd0, 0, 0, 0, 0, 0);
    cyc("wr2", 1, 4'd2, 4'd0, 1, 4'd2, 16'h6666, 0, 0);
    cyc("rd2_go", 1, 4'd2, 4'd0, 0, 0, 0, 0, 0);

    cyc("wr0", 0, 0, 0, 1, 4'd0, 16'hFFFF, 0, 0);
    chk("acc_ffff", {16'b0, bus.acc_out}, 32'hFFFF);
    cyc("rd00", 1, 4'd0, 4'd0, 0, 0, 0, 0, 0);
    chk("rd00_op2", {16'b0, bus.op2_data}, 32'hFFFF);

    cyc("rd_claim_same", 1, 4'd3, 4'd3, 0, 0, 0, 1, 4'd3);
    cyc("wr3_clear", 0, 0, 0, 1, 4'd3, 16'h4321, 0, 0);
    cyc("wr_nonpend_rd", 1, 4'd9, 4'd3, 1, 4'd9, 16'hA5A5, 0, 0);

    cyc("wr4", 0, 0, 0, 1, 4'd4, 16'h0F0F, 1, 4'd4);
    cyc("rd4_stall", 1, 4'd4, 4'd4, 0, 0, 0, 0, 0);
    bus.rd_req = 1; bus.op1_addr = 4'd4; bus.op2_addr = 4'd4;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("postrst.valid", {31'b0, bus.rd_valid}, 32'h0);
    @(posedge clk); #1;
    cyc("rd4_after_rst", 1, 4'd4, 4'd4, 0, 0, 0, 0, 0);
    chk("rd4_zero", {16'b0, bus.op1_data}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom()),
          ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++)
      cyc("drain_wr", 0, 0, 0, 1, 4'(i), 16'(i * 16'h1111), 0, 0);
    for (int i = 0; i < 16; i += 2)
      cyc("drain_rd", 1, 4'(i), 4'(i + 1), 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
